// File: rtl/mem_wb_queue.sv
// In-order MEM/WB queue: holds up to DEPTH issued ops, merges load data, retires in order.
// Latency: non-mem entry presented 1 cycle after enqueue; mem entry 1 cycle after its response.
// Backpressure: in_ready drops when full or while draining flushed responses; out_ready stalls retire.
module mem_wb_queue #(
  parameter int PW    = 256,
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PW-1:0]            in_payload,
  input  logic [XLEN-1:0]          in_x_rd,
  input  logic                     in_mem_rd,
  input  logic                     in_mem_wr,
  input  logic                     mem_r_valid,
  input  logic [XLEN-1:0]          mem_r_data,
  input  logic                     mem_w_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PW-1:0]            out_payload,
  output logic [XLEN-1:0]          out_x_rd,
  output logic                     out_is_mem,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PONE = AW'(1);
  localparam logic [CW-1:0] CONE = CW'(1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Per-entry control state (reset) and data storage (not reset)
  logic [DEPTH-1:0] ent_vld;
  logic [DEPTH-1:0] ent_mem;
  logic [DEPTH-1:0] ent_ld;
  logic [DEPTH-1:0] ent_done;
  logic [PW-1:0]    pl_mem  [DEPTH];
  logic [XLEN-1:0]  xrd_mem [DEPTH];

  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW-1:0] resp;
  logic [CW-1:0] drain;

  logic          enq;
  logic          deq;
  logic          resp_fire;
  logic          draining;
  logic          take;
  logic          mismatch;
  logic          pend_hit;
  logic [AW-1:0] pend_idx;
  logic [AW-1:0] scan_idx;
  logic [CW-1:0] pend_cnt;
  logic [CW-1:0] count_nxt;
  logic [CW-1:0] drain_nxt;
  logic          err_nxt;

  assign draining  = (drain != '0);
  assign in_ready  = (count < FULL) && !draining;
  assign out_valid = ent_vld[head] & ent_done[head];
  assign out_payload = pl_mem[head];
  assign out_x_rd    = xrd_mem[head];
  assign out_is_mem  = ent_mem[head];

  assign enq       = in_valid & in_ready & ~flush;
  assign deq       = out_valid & out_ready;
  assign resp_fire = mem_r_valid | mem_w_ready;
  assign take      = resp_fire & ~draining & pend_hit;
  // A load must be answered by read data, a store by a write ack
  assign mismatch  = ent_ld[pend_idx] ? ~mem_r_valid : ~mem_w_ready;

  // Locate the oldest entry awaiting a response, scanning forward from resp; also count pending ones
  always_comb begin
    pend_hit = 1'b0;
    pend_idx = resp;
    pend_cnt = '0;
    scan_idx = resp;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = resp + AW'(i);
      if (ent_vld[scan_idx] && ent_mem[scan_idx] && !ent_done[scan_idx]) begin
        pend_cnt = pend_cnt + CONE;
        if (!pend_hit) begin
          pend_hit = 1'b1;
          pend_idx = scan_idx;
        end
      end
    end
  end

  // Next occupancy, drain count and sticky error
  always_comb begin
    count_nxt = count;
    if (enq) count_nxt = count_nxt + CONE;
    if (deq) count_nxt = count_nxt - CONE;
    if (flush) count_nxt = '0;

    drain_nxt = drain;
    if (resp_fire && draining) drain_nxt = drain_nxt - CONE;
    if (flush) begin
      // The response completing an entry this cycle is already accounted for
      drain_nxt = drain_nxt + pend_cnt;
      if (take) drain_nxt = drain_nxt - CONE;
    end

    err_nxt = err
            | (mem_r_valid & mem_w_ready)
            | (enq & in_mem_rd & in_mem_wr)
            | (resp_fire & ~draining & ~pend_hit)
            | (take & mismatch);
  end

  // Control state: pointers, entry flags, counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_vld  <= '0;
      ent_mem  <= '0;
      ent_ld   <= '0;
      ent_done <= '0;
      head     <= '0;
      tail     <= '0;
      resp     <= '0;
      count    <= '0;
      drain    <= '0;
      err      <= 1'b0;
    end else begin
      count <= count_nxt;
      drain <= drain_nxt;
      err   <= err_nxt;

      if (deq) begin
        ent_vld[head] <= 1'b0;
        head          <= head + PONE;
      end
      if (take) ent_done[pend_idx] <= 1'b1;

      // resp tracks the oldest pending entry; with none pending it parks at tail
      if (take)          resp <= pend_idx + PONE;
      else if (pend_hit) resp <= pend_idx;
      else               resp <= tail;

      if (flush) begin
        ent_vld <= '0;
        head    <= tail;
        resp    <= tail;
      end

      if (enq) begin
        ent_vld[tail]  <= 1'b1;
        ent_mem[tail]  <= in_mem_rd | in_mem_wr;
        ent_ld[tail]   <= in_mem_rd;
        ent_done[tail] <= ~(in_mem_rd | in_mem_wr);
        tail           <= tail + PONE;
      end
    end
  end

  // Data storage: enqueue writes payload/rd, load responses overwrite rd
  always_ff @(posedge clk) begin
    if (take && mem_r_valid) xrd_mem[pend_idx] <= mem_r_data;
    if (enq) begin
      pl_mem[tail]  <= in_payload;
      xrd_mem[tail] <= in_x_rd;
    end
  end

endmodule

// File: tb/tb_mem_wb_queue.sv
// Self-checking bench for mem_wb_queue: directed scenarios plus random traffic.
// Expected values come from a queue-based reference model of the queue's rules.
// Outputs are sampled on the falling edge, inputs driven on the falling edge.
module tb_mem_wb_queue;

  localparam int PW    = 256;
  localparam int XLEN  = 64;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk;
  logic            rst;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [PW-1:0]   in_payload;
  logic [XLEN-1:0] in_x_rd;
  logic            in_mem_rd;
  logic            in_mem_wr;
  logic            mem_r_valid;
  logic [XLEN-1:0] mem_r_data;
  logic            mem_w_ready;
  logic            out_valid;
  logic            out_ready;
  logic [PW-1:0]   out_payload;
  logic [XLEN-1:0] out_x_rd;
  logic            out_is_mem;
  logic [CW-1:0]   count;
  logic            err;

  mem_wb_queue #(.PW(PW), .XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_payload(in_payload),
    .in_x_rd(in_x_rd), .in_mem_rd(in_mem_rd), .in_mem_wr(in_mem_wr),
    .mem_r_valid(mem_r_valid), .mem_r_data(mem_r_data), .mem_w_ready(mem_w_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_payload(out_payload),
    .out_x_rd(out_x_rd), .out_is_mem(out_is_mem), .count(count), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0]   pl;
    logic [XLEN-1:0] x;
    bit              mem;
    bit              ld;
    bit              done;
  } ent_t;

  ent_t mq[$];
  int   m_drain;
  bit   m_err;
  int   n_tests;
  int   n_fail;

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] rand_pl();
    logic [PW-1:0] v;
    v = '0;
    for (int i = 0; i < PW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [XLEN-1:0] rand_x();
    return {$urandom, $urandom};
  endfunction

  // -1: nothing pending, 0: oldest pending is a store, 1: oldest pending is a load
  function automatic int first_pending_kind();
    foreach (mq[k]) if (mq[k].mem && !mq[k].done) return mq[k].ld ? 1 : 0;
    return -1;
  endfunction

  task automatic clr();
    in_valid    = 1'b0;
    flush       = 1'b0;
    mem_r_valid = 1'b0;
    mem_w_ready = 1'b0;
    in_mem_rd   = 1'b0;
    in_mem_wr   = 1'b0;
  endtask

  task automatic push(input logic [XLEN-1:0] x, input logic rd, input logic wr);
    in_valid   = 1'b1;
    in_x_rd    = x;
    in_mem_rd  = rd;
    in_mem_wr  = wr;
    in_payload = rand_pl();
  endtask

  task automatic check_outputs();
    bit ev;
    ev = (mq.size() > 0) && mq[0].done;
    chk("out_valid", PW'(out_valid), PW'(ev));
    chk("count", PW'(count), PW'(mq.size()));
    chk("in_ready", PW'(in_ready), PW'((mq.size() < DEPTH) && (m_drain == 0)));
    chk("err", PW'(err), PW'(m_err));
    if (ev) begin
      chk("out_x_rd", PW'(out_x_rd), PW'(mq[0].x));
      chk("out_payload", out_payload, mq[0].pl);
      chk("out_is_mem", PW'(out_is_mem), PW'(mq[0].mem));
    end
  endtask

  // Reference model: apply one clock edge worth of the queue rules
  task automatic model_step();
    bit   irdy, ov, enq, deq, fire;
    int   j;
    ent_t e;
    irdy = (mq.size() < DEPTH) && (m_drain == 0);
    ov   = (mq.size() > 0) && mq[0].done;
    enq  = in_valid && irdy && !flush;
    deq  = ov && out_ready;
    fire = mem_r_valid || mem_w_ready;
    j    = -1;
    if (mem_r_valid && mem_w_ready) m_err = 1'b1;
    if (fire) begin
      if (m_drain > 0) m_drain--;
      else begin
        foreach (mq[k]) if (j < 0 && mq[k].mem && !mq[k].done) j = k;
        if (j < 0) m_err = 1'b1;
        else begin
          mq[j].done = 1'b1;
          if (mem_r_valid) mq[j].x = mem_r_data;
          if (mq[j].ld ? !mem_r_valid : !mem_w_ready) m_err = 1'b1;
        end
      end
    end
    if (deq) void'(mq.pop_front());
    if (flush) begin
      foreach (mq[k]) if (mq[k].mem && !mq[k].done) m_drain++;
      mq.delete();
    end
    if (enq) begin
      e.pl   = in_payload;
      e.x    = in_x_rd;
      e.mem  = in_mem_rd || in_mem_wr;
      e.ld   = in_mem_rd;
      e.done = !(in_mem_rd || in_mem_wr);
      mq.push_back(e);
      if (in_mem_rd && in_mem_wr) m_err = 1'b1;
    end
  endtask

  task automatic cycle();
    check_outputs();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  initial begin
    int kind, r;
    n_tests = 0;
    n_fail  = 0;
    m_drain = 0;
    m_err   = 1'b0;
    clr();
    out_ready  = 1'b0;
    in_payload = '0;
    in_x_rd    = '0;
    mem_r_data = '0;
    rst        = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_count", PW'(count), PW'(0));
    chk("rst_in_ready", PW'(in_ready), PW'(1));
    chk("rst_out_valid", PW'(out_valid), PW'(0));
    chk("rst_err", PW'(err), PW'(0));
    rst = 1'b1;
    @(negedge clk);

    // 1: three ALU entries stream through back to back
    out_ready = 1'b1;
    push(64'h11, 1'b0, 1'b0); cycle();
    chk("t1_first_x", PW'(out_x_rd), PW'(64'h11));
    push(64'h22, 1'b0, 1'b0); cycle();
    chk("t1_count_peak", PW'(count), PW'(1));
    push(64'h33, 1'b0, 1'b0); cycle();
    clr(); cycle(); cycle();

    // 2: ALU entry behind a load waits for the load
    push(64'h0, 1'b1, 1'b0);   cycle();
    push(64'hBB, 1'b0, 1'b0);  cycle();
    push(64'h0, 1'b1, 1'b0);   cycle();
    clr();
    chk("t2_wait_a", PW'(out_valid), PW'(0));
    mem_r_valid = 1'b1; mem_r_data = 64'hAAAA; cycle();
    clr();
    chk("t2_a_data", PW'(out_x_rd), PW'(64'hAAAA));
    cycle(); cycle();
    mem_r_valid = 1'b1; mem_r_data = 64'hCCCC; cycle();
    clr();
    chk("t2_c_data", PW'(out_x_rd), PW'(64'hCCCC));
    repeat (3) cycle();

    // 3: fill to DEPTH with retire stalled, then drain
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      push(rand_x(), 1'b0, 1'b0); cycle();
    end
    chk("t3_full_count", PW'(count), PW'(DEPTH));
    chk("t3_full_ready", PW'(in_ready), PW'(0));
    push(64'h55, 1'b0, 1'b0); cycle();
    clr();
    out_ready = 1'b1; cycle();
    chk("t3_ready_after_deq", PW'(in_ready), PW'(1));
    repeat (5) cycle();

    // 4: flush with three outstanding accesses, then drain their responses
    push(rand_x(), 1'b1, 1'b0); cycle();
    push(rand_x(), 1'b1, 1'b0); cycle();
    push(rand_x(), 1'b0, 1'b1); cycle();
    clr(); flush = 1'b1; cycle();
    clr();
    chk("t4_count", PW'(count), PW'(0));
    chk("t4_out_valid", PW'(out_valid), PW'(0));
    chk("t4_in_ready", PW'(in_ready), PW'(0));
    in_valid = 1'b1;
    mem_r_valid = 1'b1; mem_r_data = rand_x(); cycle();
    mem_r_valid = 1'b0; cycle();
    mem_r_valid = 1'b1; cycle();
    mem_r_valid = 1'b0; mem_w_ready = 1'b1; cycle();
    clr();
    chk("t4_ready_after_drain", PW'(in_ready), PW'(1));
    chk("t4_err_clean", PW'(err), PW'(0));
    cycle();

    // 5: flush coinciding with the first pending response
    push(rand_x(), 1'b1, 1'b0); cycle();
    push(rand_x(), 1'b1, 1'b0); cycle();
    clr(); flush = 1'b1; mem_r_valid = 1'b1; mem_r_data = rand_x(); cycle();
    clr();
    chk("t5_in_ready", PW'(in_ready), PW'(0));
    mem_r_valid = 1'b1; cycle();
    clr();
    chk("t5_ready_back", PW'(in_ready), PW'(1));
    cycle();

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      clr();
      out_ready = ($urandom % 4) != 0;
      if ($urandom % 2 == 1) begin
        r = int'($urandom % 7);
        push(rand_x(), r >= 3 && r < 5, r >= 5);
      end
      flush = ($urandom % 25) == 0;
      kind = first_pending_kind();
      if ((m_drain > 0 || kind >= 0) && ($urandom % 3) == 0) begin
        if (m_drain > 0) kind = int'($urandom % 2);
        if (kind == 1) begin
          mem_r_valid = 1'b1;
          mem_r_data  = rand_x();
        end else begin
          mem_w_ready = 1'b1;
        end
      end
      cycle();
    end
    clr();
    out_ready = 1'b1;
    repeat (2) cycle();
    // Flush out whatever is left so the error scenario starts clean
    flush = 1'b1; cycle(); clr();
    for (int i = 0; i < 8 && m_drain > 0; i++) begin
      mem_w_ready = (i % 2) == 0;
      mem_r_valid = 1'b0;
      cycle();
    end
    clr(); cycle();

    // 6: kind mismatch, then a stray response with an empty queue
    if (m_drain == 0) begin
      push(64'h66, 1'b1, 1'b0); cycle();
      clr(); mem_w_ready = 1'b1; cycle();
      clr();
      chk("t6_err_set", PW'(err), PW'(1));
      chk("t6_entry_done", PW'(out_valid), PW'(1));
      cycle(); cycle();
      mem_r_valid = 1'b1; mem_r_data = rand_x(); cycle();
      clr();
      push(64'h77, 1'b0, 1'b0); cycle();
      clr();
      chk("t6_alu_after_err", PW'(out_x_rd), PW'(64'h77));
      repeat (3) cycle();
      chk("t6_err_sticky", PW'(err), PW'(1));
    end else begin
      chk("drain_settled", PW'(m_drain), PW'(0));
    end

    // Asynchronous reset mid-operation
    out_ready = 1'b0;
    push(rand_x(), 1'b1, 1'b0); cycle();
    push(rand_x(), 1'b0, 1'b0); cycle();
    clr();
    #2 rst = 1'b0;
    #1;
    chk("arst_count", PW'(count), PW'(0));
    chk("arst_err", PW'(err), PW'(0));
    chk("arst_out_valid", PW'(out_valid), PW'(0));
    chk("arst_in_ready", PW'(in_ready), PW'(1));
    mq.delete();
    m_drain = 0;
    m_err   = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    push(64'h99, 1'b0, 1'b0); cycle();
    clr(); cycle(); cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
